// File: rtl/compas_mem_loader_pkg.sv
// Shared defaults and FSM state encoding for the byte-stream memory loader.
package compas_mem_loader_pkg;

    localparam int DEPTH_DEF  = 10000;
    localparam int ADDR_W_DEF = 14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_VRD   = 3'd3,
        ST_VCMP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/compas_word_packer.sv
// Packs accepted stream bytes little-endian into 32-bit words; flush drops a partial word.
module compas_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic [31:0] word,
    output logic        word_rdy
);

    logic [1:0]  byte_cnt;
    logic [31:0] shift_q;

    // Shifting in from the top leaves the first byte in [7:0] after four bytes.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            byte_cnt <= 2'd0;
            shift_q  <= 32'd0;
        end else if (in_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= {in_data, shift_q[31:8]};
        end
    end

    assign word     = shift_q;
    assign word_rdy = in_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/compas_mem_loader.sv
// Streams bytes into an on-chip memory as 32-bit words, with optional checksum readback verify.
module compas_mem_loader
    import compas_mem_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              verify_en,
    input  logic              abort,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              clken,
    input  logic [31:0]       readdata,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic              err_verify,
    output logic              err_abort
);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] vidx;
    logic              verify_q;
    logic [31:0]       wr_sum;
    logic [31:0]       rd_sum;
    logic [31:0]       word;
    logic              word_rdy;
    logic              byte_acc;
    logic              flush;
    logic              active;
    logic              start_ok;
    logic [ADDR_W:0]   end_addr;

    assign active   = (state == ST_LOAD) || (state == ST_WRITE) ||
                      (state == ST_VRD)  || (state == ST_VCMP);
    assign end_addr = {1'b0, base_addr} + {1'b0, word_count};
    assign start_ok = (word_count != '0) && (end_addr <= (ADDR_W+1)'(DEPTH));
    assign byte_acc = s_valid && s_ready && !abort;
    assign flush    = (active && abort) || ((state == ST_IDLE) && start);

    compas_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_data  (s_data),
        .in_valid (byte_acc),
        .word     (word),
        .word_rdy (word_rdy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            verify_q   <= 1'b0;
            widx       <= '0;
            vidx       <= '0;
            wr_sum     <= 32'd0;
            rd_sum     <= 32'd0;
            err_range  <= 1'b0;
            err_verify <= 1'b0;
            err_abort  <= 1'b0;
        end else if (active && abort) begin
            err_abort <= 1'b1;
            state     <= ST_DONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_verify <= 1'b0;
                        err_abort  <= 1'b0;
                        if (start_ok) begin
                            base_q    <= base_addr;
                            count_q   <= word_count;
                            verify_q  <= verify_en;
                            widx      <= '0;
                            vidx      <= '0;
                            wr_sum    <= 32'd0;
                            rd_sum    <= 32'd0;
                            err_range <= 1'b0;
                            state     <= ST_LOAD;
                        end else begin
                            err_range <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_rdy) state <= ST_WRITE;
                end
                ST_WRITE: begin
                    wr_sum <= wr_sum + word;
                    widx   <= widx + 1'b1;
                    if ((widx + 1'b1) != count_q) state <= ST_LOAD;
                    else if (verify_q)            state <= ST_VRD;
                    else                          state <= ST_DONE;
                end
                ST_VRD: begin
                    state <= ST_VCMP;
                end
                ST_VCMP: begin
                    rd_sum <= rd_sum + readdata;
                    vidx   <= vidx + 1'b1;
                    if ((vidx + 1'b1) != count_q) begin
                        state <= ST_VRD;
                    end else begin
                        err_verify <= ((rd_sum + readdata) != wr_sum);
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory strobes are decoded from state so a same-cycle abort can still veto them.
    always_comb begin
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = 32'd0;
        if (state == ST_WRITE) begin
            chipselect = !abort;
            write      = !abort;
            address    = base_q + widx;
            writedata  = word;
        end else if (state == ST_VRD) begin
            chipselect = !abort;
            address    = base_q + vidx;
        end
    end

    assign byteenable = chipselect ? 4'hF : 4'h0;
    assign s_ready    = (state == ST_LOAD);
    assign busy       = active;
    assign done       = (state == ST_DONE);
    assign clken      = 1'b1;

endmodule

// File: tb/tb_compas_mem_loader.sv
// Randomized self-checking bench for compas_mem_loader against a word-level reference model.
module tb_compas_mem_loader;

    localparam int DEPTH  = 10000;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_count = '0;
    logic              verify_en = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        s_data = 8'd0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [31:0]       writedata;
    logic              clken;
    logic [31:0]       readdata = 32'd0;
    logic              busy;
    logic              done;
    logic              err_range;
    logic              err_verify;
    logic              err_abort;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [DEPTH];
    logic [7:0]  byte_mem [64];
    bit          corrupt_en = 1'b0;
    int          corrupt_addr = 0;

    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_be_q[$];
    int          rd_addr_q[$];
    int          done_cnt = 0;
    int          cs_cnt = 0;

    always #5 clk = ~clk;

    compas_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .verify_en  (verify_en),
        .abort      (abort),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .clken      (clken),
        .readdata   (readdata),
        .busy       (busy),
        .done       (done),
        .err_range  (err_range),
        .err_verify (err_verify),
        .err_abort  (err_abort)
    );

    // Memory model: registered read, optional single-bit corruption on one address.
    always @(posedge clk) begin
        if (chipselect && write && (int'(address) < DEPTH))
            mem[address] <= writedata;
        if (int'(address) < DEPTH)
            readdata <= (corrupt_en && int'(address) == corrupt_addr) ? (mem[address] ^ 32'd1)
                                                                      : mem[address];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (chipselect) cs_cnt++;
            if (chipselect && write) begin
                wr_addr_q.push_back(int'(address));
                wr_data_q.push_back(writedata);
                wr_be_q.push_back(byteenable);
            end
            if (chipselect && !write) rd_addr_q.push_back(int'(address));
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i);
        return 32'(byte_mem[4*i]) + (32'(byte_mem[4*i+1]) << 8) +
               (32'(byte_mem[4*i+2]) << 16) + (32'(byte_mem[4*i+3]) << 24);
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_be_q.delete();
        rd_addr_q.delete();
        done_cnt = 0;
        cs_cnt   = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        t = 0;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("s_ready_wait", 32'(s_ready), 32'd1);
    endtask

    task automatic wait_done();
        for (int t = 0; t < 500 && done_cnt == 0; t++) @(negedge clk);
        @(negedge clk);
        check("done_seen", 32'(done_cnt), 32'd1);
    endtask

    // abort_at: number of bytes to send before aborting, -1 for a complete load.
    task automatic run_load(input int base, input int cnt, input bit ven,
                            input int maxgap, input int abort_at);
        bit ok;
        ok = (cnt != 0) && (base + cnt <= DEPTH);
        clear_log();
        @(negedge clk);
        base_addr  = ADDR_W'(base);
        word_count = ADDR_W'(cnt);
        verify_en  = ven;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(ok));
        if (ok) begin
            for (int i = 0; i < cnt * 4; i++) begin
                if (i == abort_at) break;
                send_byte(byte_mem[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            end
            @(negedge clk);
            s_valid = 1'b0;
            if (abort_at >= 0) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
        end
        wait_done();
    endtask

    task automatic check_run(input int base, input int cnt, input bit ven);
        bit ok;
        int nexp;
        int nrd;
        bit exp_ev;
        ok     = (cnt != 0) && (base + cnt <= DEPTH);
        nexp   = ok ? cnt : 0;
        nrd    = (ok && ven) ? cnt : 0;
        exp_ev = ok && ven && corrupt_en && corrupt_addr >= base && corrupt_addr < base + cnt;
        check("n_writes", 32'(wr_addr_q.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
            check("wr_addr", 32'(wr_addr_q[i]), 32'(base + i));
            check("wr_data", wr_data_q[i], exp_word(i));
            check("wr_be", 32'(wr_be_q[i]), 32'hF);
        end
        check("n_reads", 32'(rd_addr_q.size()), 32'(nrd));
        for (int i = 0; i < nrd && i < rd_addr_q.size(); i++)
            check("rd_addr", 32'(rd_addr_q[i]), 32'(base + i));
        check("cs_cycles", 32'(cs_cnt), 32'(nexp + nrd));
        check("err_range", 32'(err_range), 32'(!ok));
        check("err_verify", 32'(err_verify), 32'(exp_ev));
        check("err_abort", 32'(err_abort), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [31:0] got;
        got = {11'd0, busy, done, s_ready, chipselect, write, byteenable,
               err_range, err_verify, err_abort, clken, 8'd0};
        check({tag, "_flags"}, got, 32'h0000_0100);
        check({tag, "_address"}, 32'(address), 32'd0);
        check({tag, "_writedata"}, writedata, 32'd0);
    endtask

    task automatic fill_bytes(input int n);
        for (int i = 0; i < n; i++) byte_mem[i] = 8'($urandom);
    endtask

    initial begin
        int          base;
        int          cnt;
        bit          ven;
        int          saved_addr[$];
        logic [31:0] saved_data[$];
        int          t;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single word, no verify.
        byte_mem[0] = 8'h11; byte_mem[1] = 8'h22; byte_mem[2] = 8'h33; byte_mem[3] = 8'h44;
        run_load(0, 1, 1'b0, 0, -1);
        check("single_data_const", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hDEAD, 32'h4433_2211);
        check_run(0, 1, 1'b0);

        // Range rejection and exact-fit boundary.
        run_load(9998, 3, 1'b0, 0, -1);
        check_run(9998, 3, 1'b0);
        run_load(50, 0, 1'b0, 0, -1);
        check_run(50, 0, 1'b0);
        fill_bytes(8);
        run_load(DEPTH - 2, 2, 1'b1, 0, -1);
        check_run(DEPTH - 2, 2, 1'b1);

        // Verify with clean and corrupted memory.
        fill_bytes(8);
        run_load(100, 2, 1'b1, 0, -1);
        check_run(100, 2, 1'b1);
        corrupt_en = 1'b1; corrupt_addr = 101;
        run_load(100, 2, 1'b1, 0, -1);
        check_run(100, 2, 1'b1);
        corrupt_en = 1'b0;

        // Gap-free versus gapped stream over 8 words.
        fill_bytes(32);
        run_load(300, 8, 1'b0, 0, -1);
        check_run(300, 8, 1'b0);
        saved_addr = wr_addr_q;
        saved_data = wr_data_q;
        run_load(300, 8, 1'b0, 5, -1);
        check_run(300, 8, 1'b0);
        for (int i = 0; i < 8 && i < wr_addr_q.size() && i < saved_addr.size(); i++) begin
            check("gap_vs_nogap_addr", 32'(wr_addr_q[i]), 32'(saved_addr[i]));
            check("gap_vs_nogap_data", wr_data_q[i], saved_data[i]);
        end

        // Randomized loads.
        for (int k = 0; k < 8; k++) begin
            base = int'($urandom_range(0, DEPTH - 1));
            if (k == 3) base = DEPTH - 4;
            cnt  = int'($urandom_range(0, 6));
            ven  = 1'($urandom);
            corrupt_en   = ($urandom_range(0, 2) == 0);
            corrupt_addr = base + int'($urandom_range(0, 5));
            fill_bytes(24);
            run_load(base, cnt, ven, 3, -1);
            check_run(base, cnt, ven);
        end
        corrupt_en = 1'b0;

        // Abort two bytes into word 1, then sticky-until-start behaviour.
        fill_bytes(16);
        run_load(50, 4, 1'b0, 0, 6);
        check("abort_n_writes", 32'(wr_addr_q.size()), 32'd1);
        check("abort_wr_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hDEAD, exp_word(0));
        check("abort_err_abort", 32'(err_abort), 32'd1);
        check("abort_err_range", 32'(err_range), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("abort_sticky", 32'(err_abort), 32'd1);

        // Abort in IDLE does nothing.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_done", 32'(done), 32'd0);
        run_load(60, 1, 1'b0, 0, -1);
        check_run(60, 1, 1'b0);

        // Reset during LOAD.
        clear_log();
        @(negedge clk);
        base_addr = ADDR_W'(5); word_count = ADDR_W'(2); verify_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_load");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_load_no_done", 32'(done_cnt), 32'd0);
        check("rst_load_no_write", 32'(wr_addr_q.size()), 32'd0);

        // Reset during VRD.
        fill_bytes(8);
        clear_log();
        @(negedge clk);
        base_addr = ADDR_W'(20); word_count = ADDR_W'(2); verify_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(byte_mem[i], 0);
        @(negedge clk);
        s_valid = 1'b0;
        t = 0;
        while (!(chipselect && !write) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("vrd_reached", 32'(chipselect && !write), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_vrd");
        reset = 1'b0;
        clear_log();
        repeat (10) @(negedge clk);
        check("rst_vrd_no_done", 32'(done_cnt), 32'd0);
        check("rst_vrd_no_access", 32'(cs_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
